compare_seq: RTL and testbench

Multi-cycle magnitude/equality comparator for sequential garbled-circuit netlists. It consumes two N-bit operands (garbler `g_input`, evaluator `e_input`) as CC chunks of M = N/CC bits, least-significant chunk first. It accumulates borrow and equality state across chunks and produces a selectable relational result plus full lt/eq/gt flags. It generalises the single-output ≥-style carry comparator with signed support, mode selection, chunk counting, valid handshake, abort and back-to-back operation.

---
 rtl/compare_seq_if.sv | 28 ++
 rtl/compare_seq.sv | 106 ++++++++++
 tb/tb_compare_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/compare_seq_if.sv
// Operand/result bundle for the sequential comparator.
// The master side (netlist driver) supplies operand chunks and the relation select.
// The slave side (compare_seq) returns the relation result, the lt/eq/gt flags and status.
interface compare_seq_if #(
    parameter int M = 16
);
    logic         in_valid;
    logic         abort;
    logic [2:0]   mode;
    logic [M-1:0] g_input;
    logic [M-1:0] e_input;
    logic         o;
    logic         lt;
    logic         eq;
    logic         gt;
    logic         o_valid;
    logic         busy;

    modport master (
        output in_valid, abort, mode, g_input, e_input,
        input  o, lt, eq, gt, o_valid, busy
    );

    modport slave (
        input  in_valid, abort, mode, g_input, e_input,
        output o, lt, eq, gt, o_valid, busy
    );
endinterface

// File: rtl/compare_seq.sv
// Multi-cycle magnitude/equality comparator for sequential garbled-circuit netlists.
// Two N-bit operands arrive as CC chunks of M = N/CC bits, least-significant chunk first.
// A borrow chain and a running equality flag are carried between chunks.
// On the final chunk the selected relation and the full lt/eq/gt flags are registered.
// In signed mode the top chunk has its MSBs flipped, which maps two's complement order
// onto unsigned order.
module compare_seq #(
    parameter int N      = 64,
    parameter int CC     = 4,
    parameter int SIGNED = 0
) (
    input  logic         clk,
    input  logic         rst,
    compare_seq_if.slave bus
);
    localparam int M  = N / CC;
    localparam int CW = (CC > 1) ? $clog2(CC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CC - 1);

    logic [CW-1:0] cnt;
    logic          cy;
    logic          eqr;
    logic [2:0]    mreg;

    logic          first;
    logic          last;
    logic [M-1:0]  g_op;
    logic [M-1:0]  e_op;
    logic          cin;
    logic          co;
    logic          eqc;
    logic          eqacc;
    logic [2:0]    mode_eff;
    logic          rel;

    // Chunk datapath: the carry out of g + ~e + cin is "g >= e" when cin=1 and "g > e" when cin=0,
    // so the carry is formed directly as a comparison instead of a full-width adder.
    always_comb begin
        first = (cnt == '0);
        last  = (cnt == LAST);
        g_op  = bus.g_input;
        e_op  = bus.e_input;
        if (SIGNED != 0 && last) begin
            g_op[M-1] = ~g_op[M-1];
            e_op[M-1] = ~e_op[M-1];
        end
        cin      = first ? 1'b1 : cy;
        co       = (g_op > e_op) || ((g_op == e_op) && cin);
        eqc      = (bus.g_input == bus.e_input);
        eqacc    = first ? eqc : (eqr & eqc);
        mode_eff = first ? bus.mode : mreg;
        case (mode_eff)
            3'd0:    rel = eqacc;
            3'd1:    rel = ~eqacc;
            3'd2:    rel = ~co;
            3'd3:    rel = ~co | eqacc;
            3'd4:    rel = co & ~eqacc;
            3'd5:    rel = co;
            default: rel = 1'b0;
        endcase
    end

    // Chunk sequencing, abort handling and registered result/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            cy          <= 1'b1;
            eqr         <= 1'b1;
            mreg        <= 3'd0;
            bus.o       <= 1'b0;
            bus.lt      <= 1'b0;
            bus.eq      <= 1'b0;
            bus.gt      <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            bus.o_valid <= 1'b0;
            if (bus.abort) begin
                cnt      <= '0;
                cy       <= 1'b1;
                eqr      <= 1'b1;
                bus.busy <= 1'b0;
            end else if (bus.in_valid) begin
                if (first) begin
                    mreg <= bus.mode;
                end
                if (last) begin
                    bus.o       <= rel;
                    bus.eq      <= eqacc;
                    bus.gt      <= co & ~eqacc;
                    bus.lt      <= ~co;
                    bus.o_valid <= 1'b1;
                    cnt         <= '0;
                    cy          <= 1'b1;
                    eqr         <= 1'b1;
                    bus.busy    <= 1'b0;
                end else begin
                    cy       <= co;
                    eqr      <= eqacc;
                    cnt      <= cnt + CW'(1);
                    bus.busy <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_compare_seq.sv
// Testbench for compare_seq.
// Three instances share clock and reset: N=8/CC=4 unsigned, N=8/CC=4 signed (both driven with
// identical chunks) and N=8/CC=1 unsigned. Expected results come from a whole-operand reference
// model, are queued when the final chunk is driven, and are popped whenever o_valid is seen.
module tb_compare_seq;
    localparam logic [2:0] M_EQ = 3'd0;
    localparam logic [2:0] M_NE = 3'd1;
    localparam logic [2:0] M_LT = 3'd2;
    localparam logic [2:0] M_LE = 3'd3;
    localparam logic [2:0] M_GT = 3'd4;
    localparam logic [2:0] M_GE = 3'd5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] q_u[$];
    logic [3:0] q_s[$];
    logic [3:0] q_1[$];

    compare_seq_if #(.M(2)) bus_u ();
    compare_seq_if #(.M(2)) bus_s ();
    compare_seq_if #(.M(8)) bus_1 ();

    compare_seq #(.N(8), .CC(4), .SIGNED(0)) u_uns (.clk(clk), .rst(rst), .bus(bus_u));
    compare_seq #(.N(8), .CC(4), .SIGNED(1)) u_sgn (.clk(clk), .rst(rst), .bus(bus_s));
    compare_seq #(.N(8), .CC(1), .SIGNED(0)) u_cc1 (.clk(clk), .rst(rst), .bus(bus_1));

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, actual, expected);
        end
    endtask

    // Reference model on whole operands: returns {o, lt, eq, gt}
    function automatic logic [3:0] model(input logic [7:0] g, input logic [7:0] e,
                                         input logic [2:0] mode, input bit sgn);
        logic lt_m, eq_m, gt_m, o_m;
        eq_m = (g == e);
        lt_m = sgn ? ($signed(g) < $signed(e)) : (g < e);
        gt_m = !lt_m && !eq_m;
        case (mode)
            M_EQ:    o_m = eq_m;
            M_NE:    o_m = !eq_m;
            M_LT:    o_m = lt_m;
            M_LE:    o_m = lt_m || eq_m;
            M_GT:    o_m = gt_m;
            M_GE:    o_m = !lt_m;
            default: o_m = 1'b0;
        endcase
        return {o_m, lt_m, eq_m, gt_m};
    endfunction

    task automatic drive4(input logic valid, input logic abort, input logic [2:0] mode,
                          input logic [1:0] g, input logic [1:0] e);
        bus_u.in_valid = valid; bus_u.abort = abort; bus_u.mode = mode;
        bus_u.g_input  = g;     bus_u.e_input = e;
        bus_s.in_valid = valid; bus_s.abort = abort; bus_s.mode = mode;
        bus_s.g_input  = g;     bus_s.e_input = e;
    endtask

    task automatic drive1(input logic valid, input logic [2:0] mode,
                          input logic [7:0] g, input logic [7:0] e);
        bus_1.in_valid = valid; bus_1.abort = 1'b0; bus_1.mode = mode;
        bus_1.g_input  = g;     bus_1.e_input = e;
    endtask

    // One full 4-chunk comparison on both CC=4 instances, optional idle gaps between chunks
    task automatic applyStimulus(input logic [7:0] g, input logic [7:0] e, input logic [2:0] mode,
                                 input logic [2:0] mode_late, input int gap);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i > 0) checkOutput("busy_mid", bus_u.busy, 1);
            if (i == 3) begin
                q_u.push_back(model(g, e, mode, 1'b0));
                q_s.push_back(model(g, e, mode, 1'b1));
            end
            drive4(1'b1, 1'b0, (i == 0) ? mode : mode_late, g[2*i +: 2], e[2*i +: 2]);
            if (i < 3) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                    drive4(1'b0, 1'b0, mode_late, 2'd0, 2'd0);
                end
            end
        end
        @(posedge clk); #1;
        drive4(1'b0, 1'b0, mode_late, 2'd0, 2'd0);
        checkOutput("uns_valid_pulse", bus_u.o_valid, 1);
        checkOutput("sgn_valid_pulse", bus_s.o_valid, 1);
        checkOutput("busy_after_final", bus_u.busy, 0);
    endtask

    // Scoreboard for the unsigned CC=4 instance
    always @(negedge clk) begin
        if (!rst && bus_u.o_valid) begin
            if (q_u.size() == 0) checkOutput("uns_unexpected_valid", 1, 0);
            else checkOutput("uns_result", {bus_u.o, bus_u.lt, bus_u.eq, bus_u.gt}, q_u.pop_front());
        end
    end

    // Scoreboard for the signed CC=4 instance
    always @(negedge clk) begin
        if (!rst && bus_s.o_valid) begin
            if (q_s.size() == 0) checkOutput("sgn_unexpected_valid", 1, 0);
            else checkOutput("sgn_result", {bus_s.o, bus_s.lt, bus_s.eq, bus_s.gt}, q_s.pop_front());
        end
    end

    // Scoreboard for the CC=1 instance
    always @(negedge clk) begin
        if (!rst && bus_1.o_valid) begin
            if (q_1.size() == 0) checkOutput("cc1_unexpected_valid", 1, 0);
            else checkOutput("cc1_result", {bus_1.o, bus_1.lt, bus_1.eq, bus_1.gt}, q_1.pop_front());
        end
    end

    // Main stimulus sequence
    initial begin
        logic [7:0] rg, re;
        logic [2:0] rm;
        rst = 1'b1;
        drive4(1'b0, 1'b0, M_EQ, 2'd0, 2'd0);
        drive1(1'b0, M_EQ, 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset_uns", {bus_u.o, bus_u.lt, bus_u.eq, bus_u.gt, bus_u.o_valid, bus_u.busy}, 0);
        checkOutput("reset_cc1", {bus_1.o, bus_1.lt, bus_1.eq, bus_1.gt, bus_1.o_valid, bus_1.busy}, 0);
        rst = 1'b0;

        applyStimulus(8'h5A, 8'h5A, M_EQ, M_EQ, 0);
        applyStimulus(8'h80, 8'h7F, M_GT, M_GT, 0);
        applyStimulus(8'h41, 8'h40, M_GE, M_GE, 0);
        applyStimulus(8'h41, 8'h40, M_LE, M_LE, 0);
        applyStimulus(8'h10, 8'h20, M_LT, M_GT, 2);
        applyStimulus(8'h33, 8'h33, M_NE, M_EQ, 1);

        // Abort together with a chunk after two accepted chunks
        @(posedge clk); #1; drive4(1'b1, 1'b0, M_EQ, 2'd1, 2'd1);
        @(posedge clk); #1; drive4(1'b1, 1'b0, M_EQ, 2'd1, 2'd1);
        @(posedge clk); #1; drive4(1'b1, 1'b1, M_EQ, 2'd1, 2'd1);
        @(posedge clk); #1; drive4(1'b0, 1'b0, M_EQ, 2'd0, 2'd0);
        checkOutput("abort_no_valid", bus_u.o_valid, 0);
        checkOutput("abort_busy", bus_u.busy, 0);
        applyStimulus(8'hFF, 8'hFF, M_GE, M_GE, 0);

        // Reset in the middle of a comparison
        @(posedge clk); #1; drive4(1'b1, 1'b0, M_LT, 2'd2, 2'd1);
        @(posedge clk); #1; drive4(1'b1, 1'b0, M_LT, 2'd2, 2'd1);
        @(posedge clk); #1; drive4(1'b0, 1'b0, M_LT, 2'd0, 2'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_uns", {bus_u.o, bus_u.lt, bus_u.eq, bus_u.gt, bus_u.o_valid, bus_u.busy}, 0);
        checkOutput("midreset_sgn", {bus_s.o, bus_s.lt, bus_s.eq, bus_s.gt, bus_s.o_valid, bus_s.busy}, 0);
        rst = 1'b0;
        applyStimulus(8'h33, 8'hC3, M_LT, M_LT, 0);

        // Random comparisons across all modes, including the reserved ones
        for (int k = 0; k < 12; k++) begin
            rg = 8'($urandom_range(0, 255));
            re = (k % 4 == 0) ? rg : 8'($urandom_range(0, 255));
            rm = 3'($urandom_range(0, 7));
            applyStimulus(rg, re, rm, 3'($urandom_range(0, 7)), k % 2);
        end

        // CC=1 back-to-back comparisons
        @(posedge clk); #1; q_1.push_back(model(8'd3, 8'd5, M_GE, 1'b0)); drive1(1'b1, M_GE, 8'd3, 8'd5);
        @(posedge clk); #1; q_1.push_back(model(8'd5, 8'd3, M_GE, 1'b0)); drive1(1'b1, M_GE, 8'd5, 8'd3);
        checkOutput("cc1_valid_0", bus_1.o_valid, 1);
        @(posedge clk); #1; q_1.push_back(model(8'd7, 8'd7, M_GE, 1'b0)); drive1(1'b1, M_GE, 8'd7, 8'd7);
        checkOutput("cc1_valid_1", bus_1.o_valid, 1);
        checkOutput("cc1_busy", bus_1.busy, 0);
        @(posedge clk); #1; drive1(1'b0, M_GE, 8'd0, 8'd0);
        checkOutput("cc1_valid_2", bus_1.o_valid, 1);
        @(posedge clk); #1;
        checkOutput("cc1_valid_end", bus_1.o_valid, 0);
        for (int k = 0; k < 8; k++) begin
            rg = 8'($urandom_range(0, 255));
            re = 8'($urandom_range(0, 255));
            rm = 3'($urandom_range(0, 7));
            @(posedge clk); #1; q_1.push_back(model(rg, re, rm, 1'b0)); drive1(1'b1, rm, rg, re);
        end
        @(posedge clk); #1; drive1(1'b0, M_EQ, 8'd0, 8'd0);

        repeat (3) @(posedge clk);
        checkOutput("uns_queue_drained", q_u.size(), 0);
        checkOutput("sgn_queue_drained", q_s.size(), 0);
        checkOutput("cc1_queue_drained", q_1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
